// File: rtl/rr_token_arbiter.sv
// Round-robin token arbiter: one pointer scans the clients and grants a four-phase req/ack handshake.
// Optional starvation checker is compiled in with `define STARVE_CHECK_EN.
module rr_token_arbiter #(
   parameter int N            = 3,
   parameter int STARVE_LIMIT = N + 2,
   localparam int IDW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [N-1:0]   i_req,
   output logic [N-1:0]   o_ack,
   output logic [IDW-1:0] o_grant_id,
   output logic           o_busy,
   output logic           o_starve_err
);

   localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      READY = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] w_nextPtr;
   logic [IDW-1:0] w_ptrInc;
   logic [N-1:0]   r_ack;
   logic [N-1:0]   w_nextAck;
   logic [N-1:0]   w_ptrOneHot;
   logic           w_reqAtPtr;

   // The pointer wraps explicitly so non-power-of-two N never reaches an unused code.
   assign w_ptrInc = (r_ptr == LAST_ID) ? '0 : r_ptr + 1'b1;

   always_comb begin
      w_ptrOneHot = '0;
      w_reqAtPtr  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (r_ptr == IDW'(i)) begin
            w_ptrOneHot[i] = 1'b1;
            w_reqAtPtr     = i_req[i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= SCAN;
         r_ptr   <= '0;
         r_ack   <= '0;
      end else begin
         r_state <= w_nextState;
         r_ptr   <= w_nextPtr;
         r_ack   <= w_nextAck;
      end
   end

   // READY is unconditional so every grant keeps ack high for at least one cycle.
   always_comb begin
      w_nextState = r_state;
      w_nextPtr   = r_ptr;
      w_nextAck   = r_ack;
      case (r_state)
         SCAN: begin
            if (w_reqAtPtr) begin
               w_nextState = READY;
            end else begin
               w_nextPtr = w_ptrInc;
            end
         end
         READY: begin
            w_nextAck   = w_ptrOneHot;
            w_nextState = BUSY;
         end
         BUSY: begin
            if (!w_reqAtPtr) begin
               w_nextAck   = '0;
               w_nextPtr   = w_ptrInc;
               w_nextState = SCAN;
            end
         end
         default: begin
            w_nextState = SCAN;
            w_nextAck   = '0;
         end
      endcase
   end

   assign o_ack      = r_ack;
   assign o_grant_id = r_ptr;
   assign o_busy     = (r_state != SCAN);

`ifdef STARVE_CHECK_EN
   localparam int CNTW = IDW + 2;

   logic [CNTW-1:0] r_cnt [N];
   logic            r_starveErr;
   logic            w_limitHit;

   always_comb begin
      w_limitHit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'(r_cnt[i]) >= STARVE_LIMIT) begin
            w_limitHit = 1'b1;
         end
      end
   end

   // Any active grant clears all wait counters; only unserved, waiting clients accumulate.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= '0;
         end
         r_starveErr <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if ((r_ack != '0) || !i_req[i] || r_ack[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] != {CNTW{1'b1}}) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
         if (w_limitHit) begin
            r_starveErr <= 1'b1;
         end
      end
   end

   assign o_starve_err = r_starveErr;
`else
   assign o_starve_err = 1'b0;
`endif

endmodule

// File: doc/rr_token_arbiter.md
Name: rr_token_arbiter

Overview:
- Parametrised N-client round-robin token arbiter. Replaces the fixed three-controller token ring with one block.
- A single token pointer scans the clients one per cycle. The first requester it finds gets a four-phase req/ack grant.
- On release, the token passes to the next client.
- Sits between client req/ack pairs and the shared resource. Drives grant_id and busy for the datapath mux.

Parameters:
- N, 3, number of clients; legal range 2..16.
- IDW, $clog2(N), localparam, width of the pointer and grant_id.
- STARVE_LIMIT, N+2, wait-cycle bound used by the optional starvation checker.

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req  in  N  client request, one bit per client; level, held until ack then dropped by the client.
- ack  out  N  grant acknowledge, one-hot or zero.
- grant_id  out  IDW  current token pointer value.
- busy  out  1  high in READY or BUSY.
- starve_err  out  1  sticky starvation flag; tied 0 without STARVE_CHECK_EN.

Behaviour:
- Reset (rst=1 at a posedge):
  - state=SCAN, ptr=0, ack=0, busy=0, starve_err=0, starve counters=0.
  - Reset overrides everything, including mid-BUSY; ack drops on that edge.
- State machine (registers: state, ptr, ack):
  - SCAN: if req[ptr], go to READY; ptr holds. Otherwise ptr <= (ptr==N-1) ? 0 : ptr+1.
  - READY: ack[ptr] <= 1; go to BUSY. Unconditional; a req drop during READY is ignored here.
  - BUSY: if !req[ptr], then ack[ptr] <= 0, ptr <= next(ptr), go to SCAN. Otherwise hold.
- Latency:
  - A req seen at ptr on edge k produces ack high after edge k+1.
  - ack stays high for at least 1 cycle.
  - After the req drop is seen, ack falls on the same edge and the token moves.
- Outputs:
  - grant_id = ptr, registered.
  - busy = (state != SCAN), combinational from state.
  - At most one ack bit is set at any time.
- Round robin:
  - After a release, scanning starts at next(ptr), so the releasing client is checked last.
  - Worst-case idle wait (no other holder) is N-1 scan edges plus 1 READY edge.
- Wrap: ptr N-1 -> 0. Non-power-of-two N never produces ptr >= N.
- req bits for clients other than ptr are ignored until the pointer reaches them. No queuing.
- All clients idle: ptr keeps rotating; ack=0.

Optional Feature:
- Macro: STARVE_CHECK_EN.
- Defined: per client i, an IDW+2-bit counter cnt[i], driven as follows.
  - cleared when ack != 0, when !req[i], or when ack[i];
  - otherwise incremented, saturating.
  - When cnt[i] reaches STARVE_LIMIT, starve_err <= 1. It is sticky until rst.
- Undefined: no counters are synthesised; starve_err is constant 0.

Test Plan:
- N=4, rst released, req=4'b0100 held -> ptr 0,1,2 on successive edges; READY on edge 3; ack=4'b0100 after edge 4; grant_id=2, busy=1.
- N=4, req=4'b1111, each client drops req 1 cycle after its ack -> ack order 0,1,2,3,0; never two ack bits set; busy low 1 cycle between grants.
- Client 1 in BUSY drops req -> same edge: ack[1]=0, ptr=2, state SCAN; req[2] already high -> ack[2]=1 two edges later.
- rst=1 while ack=4'b0010 -> next edge: ack=0, grant_id=0, busy=0, starve_err=0.
- N=2, req=2'b10 -> ptr wraps 1->0->1 correctly; ack=2'b10.
- STARVE_CHECK_EN, N=4, STARVE_LIMIT=6 -> req[3] wait stays at most 4 cycles, starve_err=0. Same run with STARVE_LIMIT=2 -> starve_err=1 and stays set until rst.
